// File: rtl/mm_score_engine_pkg.sv
// mm_pkg: state encodings and sizing helpers shared by the Mastermind scorer files.
package mm_pkg;
  localparam logic [1:0] IDLE = 2'd0, EXACT = 2'd1, PARTIAL = 2'd2, DONE = 2'd3;
  function automatic int num_colors(input int color_w);
    return 1 << color_w;
  endfunction
  function automatic int cnt_w(input int num_pegs);
    return $clog2(num_pegs + 1);
  endfunction
  function automatic int peg_lsb(input int i, input int color_w);
    return i * color_w;
  endfunction
endpackage

// File: rtl/mm_score_engine_if.sv
// mm_score_engine_if: score request/result bundle; new_game/lost exist only with MM_TRY_LIMIT_EN.
interface mm_score_engine_if
  import mm_pkg::*;
#(
  parameter int NUM_PEGS = 4,
  parameter int COLOR_W  = 2
);
  localparam int CW = cnt_w(NUM_PEGS);
  logic                        start;
  logic [NUM_PEGS*COLOR_W-1:0] secret;
  logic [NUM_PEGS*COLOR_W-1:0] guess;
  logic                        busy;
  logic                        done;
  logic [CW-1:0]               exact_cnt;
  logic [CW-1:0]               partial_cnt;
  logic                        won;
`ifdef MM_TRY_LIMIT_EN
  logic new_game;
  logic lost;
  modport master (output start, secret, guess, new_game, input busy, done, exact_cnt, partial_cnt, won, lost);
  modport slave (input start, secret, guess, new_game, output busy, done, exact_cnt, partial_cnt, won, lost);
`else
  modport master (output start, secret, guess, input busy, done, exact_cnt, partial_cnt, won);
  modport slave (input start, secret, guess, output busy, done, exact_cnt, partial_cnt, won);
`endif
endinterface

// File: rtl/mm_score_engine_color_hist.sv
// mm_color_hist: per-colour counter bank with sync clear, increment-at-index and combinational read.
module mm_color_hist
  import mm_pkg::*;
#(
  parameter int IXW = 2,
  parameter int CW  = 3
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           inc,
  input  logic [IXW-1:0] inc_idx,
  input  logic [IXW-1:0] rd_idx,
  output logic [CW-1:0]  rd_data
);
  localparam int NC = num_colors(IXW);
  logic [CW-1:0] cnt [NC];
  always_ff @(posedge clk)
    if (clr) for (int i = 0; i < NC; i++) cnt[i] <= '0;
    else if (inc) cnt[inc_idx] <= cnt[inc_idx] + CW'(1);
  assign rd_data = cnt[rd_idx];
endmodule

// File: rtl/mm_score_engine.sv
// mm_score_engine: sequential multiset Mastermind scorer (exact pass, then per-colour min pass).
// Optional try limit with new_game/lost when MM_TRY_LIMIT_EN is defined.
module mm_score_engine
  import mm_pkg::*;
#(
  parameter int NUM_PEGS  = 4,
  parameter int COLOR_W   = 2,
  parameter int MAX_TRIES = 8
) (
  input logic clk,
  input logic Reset,
  mm_score_engine_if.slave bus
);
  localparam int CW = cnt_w(NUM_PEGS);
  localparam int IW = $clog2(NUM_PEGS);
  if (NUM_PEGS < 2 || MAX_TRIES < 1) begin : g_bad_params
    $error("mm_score_engine: NUM_PEGS must be >= 2 and MAX_TRIES >= 1");
  end
  logic [1:0] state;
  logic [NUM_PEGS*COLOR_W-1:0] sec, gss;
  logic [IW-1:0] idx;
  logic [COLOR_W-1:0] col, sp, gp;
  logic [CW-1:0] exact_acc, partial_acc, sec_rd, gss_rd, lo;
  logic accept, hit;
  assign sp = sec[peg_lsb(int'(idx), COLOR_W) +: COLOR_W];
  assign gp = gss[peg_lsb(int'(idx), COLOR_W) +: COLOR_W];
  assign hit = sp == gp;
  assign lo = sec_rd < gss_rd ? sec_rd : gss_rd;
  assign bus.busy = state != IDLE;
  mm_color_hist #(.IXW(COLOR_W), .CW(CW)) u_sec_hist (
    .clk(clk), .clr(Reset || accept), .inc(state == EXACT && !hit),
    .inc_idx(sp), .rd_idx(col), .rd_data(sec_rd)
  );
  mm_color_hist #(.IXW(COLOR_W), .CW(CW)) u_gss_hist (
    .clk(clk), .clr(Reset || accept), .inc(state == EXACT && !hit),
    .inc_idx(gp), .rd_idx(col), .rd_data(gss_rd)
  );
`ifdef MM_TRY_LIMIT_EN
  localparam int TW = $clog2(MAX_TRIES + 1);
  logic [TW-1:0] tries;
  logic ng_pend, ng;
  // new_game seen while busy is remembered and applied once back in IDLE
  assign ng = bus.new_game || ng_pend;
  assign accept = state == IDLE && bus.start && !bus.lost && !ng;
  always_ff @(posedge clk)
    if (Reset) begin
      tries <= '0;
      bus.lost <= 1'b0;
      ng_pend <= 1'b0;
    end else if (state == DONE && exact_acc != CW'(NUM_PEGS)) begin
      tries <= tries + TW'(1);
      bus.lost <= tries + TW'(1) == TW'(MAX_TRIES);
      ng_pend <= ng_pend || bus.new_game;
    end else if (state == IDLE && ng) begin
      tries <= '0;
      bus.lost <= 1'b0;
      ng_pend <= 1'b0;
    end else ng_pend <= ng_pend || bus.new_game;
`else
  assign accept = state == IDLE && bus.start;
`endif
  always_ff @(posedge clk)
    if (accept) begin
      sec <= bus.secret;
      gss <= bus.guess;
    end
  always_ff @(posedge clk)
    if (Reset) begin
      state <= IDLE;
      idx <= '0;
      col <= '0;
      exact_acc <= '0;
      partial_acc <= '0;
      bus.done <= 1'b0;
      bus.exact_cnt <= '0;
      bus.partial_cnt <= '0;
      bus.won <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          idx <= '0;
          col <= '0;
          exact_acc <= '0;
          partial_acc <= '0;
          state <= EXACT;
        end
        EXACT: begin
          exact_acc <= exact_acc + CW'(hit);
          idx <= idx + IW'(1);
          if (idx == IW'(NUM_PEGS - 1)) state <= PARTIAL;
        end
        PARTIAL: begin
          partial_acc <= partial_acc + lo;
          col <= col + COLOR_W'(1);
          if (col == '1) state <= DONE;
        end
        default: begin
          bus.done <= 1'b1;
          bus.exact_cnt <= exact_acc;
          bus.partial_cnt <= partial_acc;
          bus.won <= exact_acc == CW'(NUM_PEGS);
          state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_mm_score_engine.sv
// tb_mm_score_engine: directed checks of the 4x2 scorer plus a 6x3 instance against a common-colour reference model.
module tb_mm_score_engine;
  logic clk = 1'b0;
  logic Reset = 1'b1;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  mm_score_engine_if #(.NUM_PEGS(4), .COLOR_W(2)) bus ();
  mm_score_engine_if #(.NUM_PEGS(6), .COLOR_W(3)) bus6 ();
  mm_score_engine #(.NUM_PEGS(4), .COLOR_W(2), .MAX_TRIES(2)) dut (.clk(clk), .Reset(Reset), .bus(bus));
  mm_score_engine #(.NUM_PEGS(6), .COLOR_W(3), .MAX_TRIES(8)) dut6 (.clk(clk), .Reset(Reset), .bus(bus6));

  function automatic logic [7:0] pk(input int p0, input int p1, input int p2, input int p3);
    logic [1:0] a, b, c, d;
    a = p0[1:0]; b = p1[1:0]; c = p2[1:0]; d = p3[1:0];
    return {d, c, b, a};
  endfunction

  function automatic logic [17:0] pk6(input int p0, input int p1, input int p2, input int p3, input int p4, input int p5);
    int p[6];
    logic [17:0] r;
    p = '{p0, p1, p2, p3, p4, p5};
    r = '0;
    for (int i = 0; i < 6; i++) r[i*3 +: 3] = 3'(p[i]);
    return r;
  endfunction

  // Reference: common colours over full codes minus exact hits gives the partial count.
  function automatic void model6(input logic [17:0] s, input logic [17:0] g, output int ex, output int pa);
    int hs[8], hg[8], common;
    hs = '{default: 0}; hg = '{default: 0}; ex = 0; common = 0;
    for (int i = 0; i < 6; i++) begin
      hs[s[i*3 +: 3]]++;
      hg[g[i*3 +: 3]]++;
      if (s[i*3 +: 3] == g[i*3 +: 3]) ex++;
    end
    for (int c = 0; c < 8; c++) common += (hs[c] < hg[c]) ? hs[c] : hg[c];
    pa = common - ex;
  endfunction

  task automatic clear_game;
`ifdef MM_TRY_LIMIT_EN
    bus.new_game = 1'b1;
`endif
    @(posedge clk); @(negedge clk);
`ifdef MM_TRY_LIMIT_EN
    bus.new_game = 1'b0;
`endif
  endtask

  task automatic go(input logic [7:0] s, input logic [7:0] g, output int lat, output logic b1);
    bus.secret = s; bus.guess = g; bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    lat = 0; b1 = 1'b0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) b1 = bus.busy;
      if (bus.done) lat = c;
    end
  endtask

  task automatic run_score(input logic [7:0] s, input logic [7:0] g, output int lat, output logic b1);
    clear_game();
    go(s, g, lat, b1);
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.exact_cnt !== 3'd0) begin bad++; $display("FAIL reset_exact got=%0d want=0", bus.exact_cnt); end
    total++; if (bus.partial_cnt !== 3'd0) begin bad++; $display("FAIL reset_partial got=%0d want=0", bus.partial_cnt); end
    total++; if (bus.won !== 1'b0) begin bad++; $display("FAIL reset_won got=%b want=0", bus.won); end
`ifdef MM_TRY_LIMIT_EN
    total++; if (bus.lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%b want=0", bus.lost); end
`endif
    Reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    logic b1;
    run_score(pk(3, 3, 1, 0), pk(1, 2, 3, 2), lat, b1);
    total++; if (lat !== 9) begin bad++; $display("FAIL v1_latency got=%0d want=9", lat); end
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL v1_busy got=%b want=1", b1); end
    total++; if (bus.exact_cnt !== 3'd0) begin bad++; $display("FAIL v1_exact got=%0d want=0", bus.exact_cnt); end
    total++; if (bus.partial_cnt !== 3'd2) begin bad++; $display("FAIL v1_partial got=%0d want=2", bus.partial_cnt); end
    total++; if (bus.won !== 1'b0) begin bad++; $display("FAIL v1_won got=%b want=0", bus.won); end
    repeat (3) @(negedge clk);
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL v1_done_pulse got=%b want=0", bus.done); end
    total++; if (bus.partial_cnt !== 3'd2) begin bad++; $display("FAIL v1_hold got=%0d want=2", bus.partial_cnt); end
    run_score(pk(3, 2, 3, 3), pk(3, 2, 3, 3), lat, b1);
    total++; if (lat !== 9) begin bad++; $display("FAIL v2_latency got=%0d want=9", lat); end
    total++; if (bus.exact_cnt !== 3'd4) begin bad++; $display("FAIL v2_exact got=%0d want=4", bus.exact_cnt); end
    total++; if (bus.partial_cnt !== 3'd0) begin bad++; $display("FAIL v2_partial got=%0d want=0", bus.partial_cnt); end
    total++; if (bus.won !== 1'b1) begin bad++; $display("FAIL v2_won got=%b want=1", bus.won); end
  endtask

  task automatic test_duplicates;
    int lat;
    logic b1;
    run_score(pk(0, 1, 3, 2), pk(1, 1, 1, 1), lat, b1);
    total++; if (bus.exact_cnt !== 3'd1) begin bad++; $display("FAIL dup1_exact got=%0d want=1", bus.exact_cnt); end
    total++; if (bus.partial_cnt !== 3'd0) begin bad++; $display("FAIL dup1_partial got=%0d want=0", bus.partial_cnt); end
    run_score(pk(1, 2, 1, 0), pk(1, 3, 1, 2), lat, b1);
    total++; if (bus.exact_cnt !== 3'd2) begin bad++; $display("FAIL dup2_exact got=%0d want=2", bus.exact_cnt); end
    total++; if (bus.partial_cnt !== 3'd1) begin bad++; $display("FAIL dup2_partial got=%0d want=1", bus.partial_cnt); end
    total++; if (bus.won !== 1'b0) begin bad++; $display("FAIL dup2_won got=%b want=0", bus.won); end
  endtask

  task automatic test_busy_start;
    int dones = 0, at = 0, lat;
    logic b1;
    clear_game();
    bus.secret = pk(3, 3, 1, 0); bus.guess = pk(1, 2, 3, 2); bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); @(negedge clk);
      if (c == 1) begin
        total++; if (bus.exact_cnt !== 3'd2) begin bad++; $display("FAIL busy_keep_exact got=%0d want=2", bus.exact_cnt); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_high got=%b want=1", bus.busy); end
      end
      if (bus.done) begin dones++; at = c; end
      bus.start = (c == 2 || c == 5);
    end
    total++; if (dones !== 1) begin bad++; $display("FAIL busy_done_count got=%0d want=1", dones); end
    total++; if (at !== 9) begin bad++; $display("FAIL busy_done_cycle got=%0d want=9", at); end
    total++; if (bus.partial_cnt !== 3'd2) begin bad++; $display("FAIL busy_partial got=%0d want=2", bus.partial_cnt); end
    clear_game();
    bus.secret = pk(3, 2, 3, 3); bus.guess = pk(3, 2, 3, 3); bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    Reset = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    total++; if (bus.partial_cnt !== 3'd0) begin bad++; $display("FAIL abort_partial got=%0d want=0", bus.partial_cnt); end
    Reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 15; c++) begin @(posedge clk); @(negedge clk); if (bus.done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", dones); end
    total++; if (bus.exact_cnt !== 3'd0) begin bad++; $display("FAIL abort_exact got=%0d want=0", bus.exact_cnt); end
    run_score(pk(3, 3, 1, 0), pk(1, 2, 3, 2), lat, b1);
    total++; if (lat !== 9) begin bad++; $display("FAIL abort_resume_latency got=%0d want=9", lat); end
    total++; if (bus.partial_cnt !== 3'd2) begin bad++; $display("FAIL abort_resume_partial got=%0d want=2", bus.partial_cnt); end
  endtask

  task automatic test_back_to_back;
    int n = 0, at[2], ex[2], pa[2];
    logic w[2];
    clear_game();
    bus.secret = pk(3, 3, 1, 0); bus.guess = pk(1, 2, 3, 2); bus.start = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.guess = pk(3, 3, 1, 0);
    for (int c = 1; c <= 30 && n < 2; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.done) begin
        at[n] = c; ex[n] = int'(bus.exact_cnt); pa[n] = int'(bus.partial_cnt); w[n] = bus.won;
        n++;
        if (n == 2) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    total++; if (n !== 2) begin bad++; $display("FAIL b2b_count got=%0d want=2", n); end
    if (n == 2) begin
      total++; if (at[0] !== 9) begin bad++; $display("FAIL b2b_first_cycle got=%0d want=9", at[0]); end
      total++; if (at[1] !== 19) begin bad++; $display("FAIL b2b_second_cycle got=%0d want=19", at[1]); end
      total++; if (ex[0] !== 0 || pa[0] !== 2) begin bad++; $display("FAIL b2b_first_result got=%0d/%0d want=0/2", ex[0], pa[0]); end
      total++; if (ex[1] !== 4 || pa[1] !== 0 || w[1] !== 1'b1) begin bad++; $display("FAIL b2b_second_result got=%0d/%0d/%b want=4/0/1", ex[1], pa[1], w[1]); end
    end
    repeat (12) @(negedge clk);
  endtask

`ifdef MM_TRY_LIMIT_EN
  task automatic test_try_limit;
    int lat;
    logic b1;
    clear_game();
    go(pk(3, 3, 1, 0), pk(1, 2, 3, 2), lat, b1);
    total++; if (bus.lost !== 1'b0) begin bad++; $display("FAIL try1_lost got=%b want=0", bus.lost); end
    go(pk(0, 1, 3, 2), pk(1, 1, 1, 1), lat, b1);
    total++; if (lat !== 9 || bus.lost !== 1'b1) begin bad++; $display("FAIL try2_lost got=%0d/%b want=9/1", lat, bus.lost); end
    go(pk(3, 3, 1, 0), pk(1, 2, 3, 2), lat, b1);
    total++; if (lat !== 0 || b1 !== 1'b0) begin bad++; $display("FAIL try3_ignored got=%0d/%b want=0/0", lat, b1); end
    clear_game();
    total++; if (bus.lost !== 1'b0) begin bad++; $display("FAIL newgame_lost got=%b want=0", bus.lost); end
    go(pk(3, 2, 3, 3), pk(3, 2, 3, 3), lat, b1);
    total++; if (lat !== 9 || bus.won !== 1'b1) begin bad++; $display("FAIL newgame_resume got=%0d/%b want=9/1", lat, bus.won); end
  endtask
`endif

  task automatic test_wide;
    logic [17:0] s[8], g[8];
    int ex, pa, lat;
    s[0] = pk6(7, 7, 1, 0, 5, 2); g[0] = pk6(1, 2, 7, 2, 6, 6);
    s[1] = pk6(3, 2, 3, 3, 6, 1); g[1] = pk6(3, 2, 3, 3, 6, 1);
    s[2] = pk6(0, 1, 3, 2, 4, 4); g[2] = pk6(1, 1, 1, 1, 1, 1);
    s[3] = pk6(1, 2, 1, 0, 7, 1); g[3] = pk6(1, 3, 1, 2, 1, 0);
    for (int v = 4; v < 8; v++) begin s[v] = 18'($urandom); g[v] = 18'($urandom); end
    for (int v = 0; v < 8; v++) begin
`ifdef MM_TRY_LIMIT_EN
      bus6.new_game = 1'b1; @(posedge clk); @(negedge clk); bus6.new_game = 1'b0;
`endif
      model6(s[v], g[v], ex, pa);
      bus6.secret = s[v]; bus6.guess = g[v]; bus6.start = 1'b1;
      @(posedge clk); @(negedge clk);
      bus6.start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin @(posedge clk); @(negedge clk); if (bus6.done) lat = c; end
      total++; if (lat !== 15) begin bad++; $display("FAIL wide%0d_latency got=%0d want=15", v, lat); end
      total++; if (int'(bus6.exact_cnt) !== ex) begin bad++; $display("FAIL wide%0d_exact got=%0d want=%0d", v, bus6.exact_cnt, ex); end
      total++; if (int'(bus6.partial_cnt) !== pa) begin bad++; $display("FAIL wide%0d_partial got=%0d want=%0d", v, bus6.partial_cnt, pa); end
      total++; if (bus6.won !== (ex == 6)) begin bad++; $display("FAIL wide%0d_won got=%b want=%b", v, bus6.won, ex == 6); end
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.secret = '0; bus.guess = '0;
    bus6.start = 1'b0; bus6.secret = '0; bus6.guess = '0;
`ifdef MM_TRY_LIMIT_EN
    bus.new_game = 1'b0; bus6.new_game = 1'b0;
`endif
    @(negedge clk);
    test_reset();
    test_basic();
    test_duplicates();
    test_busy_start();
    test_back_to_back();
`ifdef MM_TRY_LIMIT_EN
    test_try_limit();
`endif
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
